// File: rtl/pipe_pkg.sv
// Shared constants and helpers for the pipeline stage chain.
// Holds default geometry and the instruction-payload field offsets used by the datapath.
package pipe_pkg;

  localparam int DEFAULT_WIDTH = 32;
  localparam int DEFAULT_DEPTH = 3;
  localparam int MAX_DEPTH     = 16;

  // Field offsets of the packed instruction carried in each stage payload
  localparam int PL_OPCODE_LSB = 0;
  localparam int PL_OPCODE_W   = 7;
  localparam int PL_RD_LSB     = 7;
  localparam int PL_RD_W       = 5;
  localparam int PL_FUNCT3_LSB = 12;
  localparam int PL_FUNCT3_W   = 3;
  localparam int PL_RS1_LSB    = 15;
  localparam int PL_RS1_W      = 5;
  localparam int PL_RS2_LSB    = 20;
  localparam int PL_RS2_W      = 5;
  localparam int PL_FUNCT7_LSB = 25;
  localparam int PL_FUNCT7_W   = 7;

  function automatic int cnt_w(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/pipe_stage_reg.sv
// One pipeline stage: valid flop plus payload flop with load/hold.
// The payload only moves when the incoming item is valid, so bubbles never disturb it.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             load,
  input  logic             src_valid,
  input  logic [WIDTH-1:0] src_data,
  output logic             valid,
  output logic [WIDTH-1:0] data
);

  logic             valid_reg;
  logic [WIDTH-1:0] data_reg;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else if (load) begin
      valid_reg <= src_valid;
      if (src_valid) begin
        data_reg <= src_data;
      end
    end
  end

  assign valid = valid_reg;
  assign data  = data_reg;

endmodule

// File: rtl/pipe_stage_chain.sv
// DEPTH-stage ready/valid register chain with bubble collapse and per-stage flush.
// Optional input skid register when PIPE_SKID_EN is defined (breaks the combinational ready path).
module pipe_stage_chain
  import pipe_pkg::*;
#(
  parameter  int WIDTH = DEFAULT_WIDTH,
  parameter  int DEPTH = DEFAULT_DEPTH,
  localparam int CNT_W = cnt_w(DEPTH)
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [DEPTH-1:0] flush,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [DEPTH-1:0] stage_valid,
  output logic [CNT_W-1:0] occupancy
);

  logic [DEPTH-1:0] valid_q;
  logic [DEPTH-1:0] eff_valid;
  logic [DEPTH:0]   rdy;
  logic [WIDTH-1:0] data_q [DEPTH];
  logic             src0_valid;
  logic [WIDTH-1:0] src0_data;
  logic [CNT_W-1:0] occ_sum;

  // A flushed item is invisible for the whole cycle, so its stage is free to load
  assign eff_valid = valid_q & ~flush;

  always_comb begin
    rdy        = '0;
    rdy[DEPTH] = out_ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy[i] = ~eff_valid[i] | rdy[i+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             src_valid;
      logic [WIDTH-1:0] src_data;

      if (gi == 0) begin : g_head
        assign src_valid = src0_valid;
        assign src_data  = src0_data;
      end else begin : g_body
        assign src_valid = eff_valid[gi-1];
        assign src_data  = data_q[gi-1];
      end

      pipe_stage_reg #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (rdy[gi]),
        .src_valid(src_valid),
        .src_data (src_data),
        .valid    (valid_q[gi]),
        .data     (data_q[gi])
      );
    end
  endgenerate

`ifdef PIPE_SKID_EN
  logic             skid_valid_reg;
  logic [WIDTH-1:0] skid_data_reg;
  logic             accept;

  assign in_ready = ~skid_valid_reg;
  assign accept   = in_valid & in_ready;

  // A parked item always goes ahead of new input; in_ready is low while it waits
  assign src0_valid = skid_valid_reg | in_valid;
  assign src0_data  = skid_valid_reg ? skid_data_reg : in_data;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      skid_valid_reg <= 1'b0;
      skid_data_reg  <= '0;
    end else if (skid_valid_reg) begin
      if (rdy[0]) begin
        skid_valid_reg <= 1'b0;
      end
    end else if (accept && !rdy[0]) begin
      skid_valid_reg <= 1'b1;
      skid_data_reg  <= in_data;
    end
  end
`else
  assign in_ready   = rdy[0];
  assign src0_valid = in_valid;
  assign src0_data  = in_data;
`endif

  always_comb begin
    occ_sum = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ_sum = occ_sum + CNT_W'(valid_q[i]);
    end
  end

  assign out_valid   = eff_valid[DEPTH-1];
  assign out_data    = data_q[DEPTH-1];
  assign stage_valid = valid_q;
  assign occupancy   = occ_sum;

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench for pipe_stage_chain (DEPTH=3, WIDTH=32) with hand-computed expectations.
// One line is printed per comparison; mismatches are reported with FAIL.
module tb_pipe_stage_chain;

  localparam int WIDTH = 32;
  localparam int DEPTH = 3;
  localparam int CNT_W = $clog2(DEPTH + 1);
`ifdef PIPE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic             clock;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic [DEPTH-1:0] flush;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [DEPTH-1:0] stage_valid;
  logic [CNT_W-1:0] occupancy;

  int total = 0;
  int bad   = 0;

  pipe_stage_chain #(
    .WIDTH(WIDTH),
    .DEPTH(DEPTH)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .stage_valid(stage_valid),
    .occupancy  (occupancy)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  initial begin
    // 1: reset clears outputs without any clock edge
    reset_n   = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hDEADBEEF;
    out_ready = 1'b0;
    flush     = '0;
    #2;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_stage_valid", 32'(stage_valid), 32'd0);
    check("rst_occupancy", 32'(occupancy), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_out_data", out_data, 32'd0);
    tick();
    tick();
    in_valid = 1'b0;
    reset_n  = 1'b1;
    #1;

    // 2: streaming, first item appears after the third edge
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (k < 4) begin
        in_valid = 1'b1;
        in_data  = 32'h10 + 32'(k);
      end else begin
        in_valid = 1'b0;
        in_data  = '0;
      end
      #1;
      check("stream_in_ready", 32'(in_ready), 32'd1);
      tick();
      if (k == 1) check("stream_not_yet", 32'(out_valid), 32'd0);
      if (k >= 2) begin
        check("stream_out_valid", 32'(out_valid), 32'd1);
        check("stream_out_data", out_data, 32'h10 + 32'(k - 2));
      end
    end
    in_valid = 1'b0;
    tick();
    check("stream_drained", 32'(out_valid), 32'd0);

    // 3: backpressure fills the chain, then drains in order
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hA0 + 32'(k);
      #1;
      check("bp_in_ready", 32'(in_ready), (k < 3 || SKID) ? 32'd1 : 32'd0);
      tick();
    end
    check("bp_occupancy", 32'(occupancy), 32'd3);
    check("bp_stage_valid", 32'(stage_valid), 32'b111);
    check("bp_full_in_ready", 32'(in_ready), 32'd0);
    if (SKID) in_valid = 1'b0;
    out_ready = 1'b1;
    #1;
    check("bp_rise_in_ready", 32'(in_ready), SKID ? 32'd0 : 32'd1);
    for (int k = 0; k < 4; k++) begin
      check("bp_out_valid", 32'(out_valid), 32'd1);
      check("bp_out_data", out_data, 32'hA0 + 32'(k));
      tick();
      in_valid = 1'b0;
    end
    check("bp_drained", 32'(out_valid), 32'd0);

    // 4: bubble collapse while the output is stalled
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_data   = 32'hB0;
    tick();
    in_valid = 1'b0;
    tick();
    tick();
    in_valid = 1'b1;
    in_data  = 32'hB1;
    tick();
    in_valid = 1'b0;
    tick();
    check("bub_stage_valid", 32'(stage_valid), 32'b110);
    check("bub_occupancy", 32'(occupancy), 32'd2);
    check("bub_out_data", out_data, 32'hB0);
    out_ready = 1'b1;
    tick();
    check("bub_second_valid", 32'(out_valid), 32'd1);
    check("bub_second_data", out_data, 32'hB1);
    tick();
    check("bub_drained", 32'(out_valid), 32'd0);

    // 5: flush kills old items while a new one loads into stage 0
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'hC2 - 32'(k);
      tick();
    end
    check("fl_full", 32'(stage_valid), 32'b111);
    flush    = 3'b011;
    in_data  = 32'hD0;
    in_valid = 1'b1;
    #1;
    check("fl_in_ready", 32'(in_ready), 32'd1);
    tick();
    flush    = '0;
    in_valid = 1'b0;
    #1;
    check("fl_stage_valid", 32'(stage_valid), 32'b101);
    check("fl_occupancy", 32'(occupancy), 32'd2);
    check("fl_out_data", out_data, 32'hC2);
    flush     = 3'b100;
    out_ready = 1'b1;
    #1;
    check("fl_out_killed", 32'(out_valid), 32'd0);
    tick();
    flush = '0;
    #1;
    check("fl_after_kill", 32'(stage_valid), 32'b010);
    tick();
    check("fl_d0_valid", 32'(out_valid), 32'd1);
    check("fl_d0_data", out_data, 32'hD0);
    tick();
    check("fl_drained", 32'(occupancy), 32'd0);

    // 6: reset in the middle of operation
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      in_valid = 1'b1;
      in_data  = 32'h61 + 32'(k);
      tick();
    end
    in_valid = 1'b0;
    check("mr_occ_before", 32'(occupancy), 32'd3);
    #3;
    reset_n = 1'b0;
    #1;
    check("mr_out_valid", 32'(out_valid), 32'd0);
    check("mr_occupancy", 32'(occupancy), 32'd0);
    check("mr_out_data", out_data, 32'd0);
    tick();
    reset_n   = 1'b1;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'hE0;
    tick();
    in_valid = 1'b0;
    check("mr_e0_edge1", 32'(out_valid), 32'd0);
    tick();
    check("mr_e0_edge2", 32'(out_valid), 32'd0);
    tick();
    check("mr_e0_valid", 32'(out_valid), 32'd1);
    check("mr_e0_data", out_data, 32'hE0);
`ifdef PIPE_SKID_EN
    check("mr_skid_empty", 32'(dut.skid_valid_reg), 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
